// File: rtl/orv64_typedef_pkg.sv
// Shared ORV64 types for the PMP request arbiter: physical address, access type,
// byte mask, exception cause, arbiter FSM states and requester ids.
package orv64_typedef_pkg;

  typedef logic [55:0] orv64_paddr_t;
  typedef logic [1:0]  orv64_access_type_t;
  typedef logic [7:0]  cpu_byte_mask_t;
  typedef logic [3:0]  orv64_excp_cause_t;

  localparam orv64_access_type_t ORV64_ACCESS_FETCH = 2'd0;
  localparam orv64_access_type_t ORV64_ACCESS_LOAD  = 2'd1;
  localparam orv64_access_type_t ORV64_ACCESS_STORE = 2'd2;
  localparam orv64_access_type_t ORV64_ACCESS_AMO   = 2'd3;

  localparam orv64_excp_cause_t ORV64_EXCP_INST_ACCESS_FAULT  = 4'd1;
  localparam orv64_excp_cause_t ORV64_EXCP_LOAD_ACCESS_FAULT  = 4'd5;
  localparam orv64_excp_cause_t ORV64_EXCP_STORE_ACCESS_FAULT = 4'd7;

  typedef enum logic [1:0] {
    ORV64_PMP_ARB_IDLE  = 2'd0,
    ORV64_PMP_ARB_CHECK = 2'd1,
    ORV64_PMP_ARB_RESP  = 2'd2
  } orv64_pmp_arb_state_t;

  localparam logic ORV64_PMP_REQ_IFU = 1'b0;
  localparam logic ORV64_PMP_REQ_LSU = 1'b1;

  function automatic logic [1:0] id_to_onehot(logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/orv64_rr_arb2.sv
// Two-way arbiter: round-robin against the last granted id, or fixed priority
// with requester 0 winning ties.
module orv64_rr_arb2 #(
  parameter bit FAIR_RR = 1'b1
) (
  input  logic [1:0] valid,
  input  logic       last_id,
  output logic       grant_vld,
  output logic       grant_id
);

  always_comb begin
    grant_vld = |valid;
    grant_id  = 1'b0;
    if (valid == 2'b11) begin
      grant_id = FAIR_RR ? ~last_id : 1'b0;
    end else begin
      grant_id = valid[1];
    end
  end

endmodule

// File: rtl/orv64_pmp_req_arb.sv
// Arbitrates fetch and load/store PMP requests into a single slot, presents the
// slot to the external PMP checker for one cycle, then holds the registered result.
module orv64_pmp_req_arb
  import orv64_typedef_pkg::*;
#(
  parameter bit FAIR_RR = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  orv64_paddr_t [1:0]        req_paddr,
  input  orv64_access_type_t [1:0]  req_access_type,
  input  cpu_byte_mask_t [1:0]      req_byte_width,
  output logic [1:0]                resp_valid,
  input  logic [1:0]                resp_ready,
  output logic                      resp_excp_valid,
  output orv64_excp_cause_t         resp_excp_cause,
  output logic                      chk_paddr_valid,
  output orv64_paddr_t              chk_paddr,
  output orv64_access_type_t        chk_access_type,
  output cpu_byte_mask_t            chk_access_byte_width,
  input  logic                      chk_excp_valid,
  input  orv64_excp_cause_t         chk_excp_cause
);

  orv64_pmp_arb_state_t state_q, state_d;

  logic               last_id_q;
  logic               grant_vld;
  logic               grant_id;
  logic               accept;
  logic               resp_on;

  orv64_paddr_t       slot_paddr_p0;
  orv64_access_type_t slot_type_p0;
  cpu_byte_mask_t     slot_bw_p0;
  logic               slot_owner_p0;

  logic               excp_vld_p1;
  orv64_excp_cause_t  excp_cause_p1;

  orv64_rr_arb2 #(
    .FAIR_RR (FAIR_RR)
  ) u_arb (
    .valid     (req_valid),
    .last_id   (last_id_q),
    .grant_vld (grant_vld),
    .grant_id  (grant_id)
  );

  // rst gates the grant so nothing is offered while reset is held
  assign req_ready = (state_q == ORV64_PMP_ARB_IDLE && !flush && !rst && grant_vld)
                     ? id_to_onehot(grant_id) : 2'b00;
  assign accept    = |(req_valid & req_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ORV64_PMP_ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ORV64_PMP_ARB_IDLE: begin
        if (accept) state_d = ORV64_PMP_ARB_CHECK;
      end
      ORV64_PMP_ARB_CHECK: begin
        state_d = flush ? ORV64_PMP_ARB_IDLE : ORV64_PMP_ARB_RESP;
      end
      ORV64_PMP_ARB_RESP: begin
        if (flush || resp_ready[slot_owner_p0]) state_d = ORV64_PMP_ARB_IDLE;
      end
      default: state_d = ORV64_PMP_ARB_IDLE;
    endcase
  end

  // p0: request slot and round-robin pointer, loaded on handshake only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_paddr_p0 <= '0;
      slot_type_p0  <= '0;
      slot_bw_p0    <= '0;
      slot_owner_p0 <= 1'b0;
      last_id_q     <= 1'b0;
    end else if (accept) begin
      slot_paddr_p0 <= req_paddr[grant_id];
      slot_type_p0  <= req_access_type[grant_id];
      slot_bw_p0    <= req_byte_width[grant_id];
      slot_owner_p0 <= grant_id;
      last_id_q     <= grant_id;
    end
  end

  // p1: checker verdict captured at the end of CHECK
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      excp_vld_p1   <= 1'b0;
      excp_cause_p1 <= '0;
    end else if (state_q == ORV64_PMP_ARB_CHECK && !flush) begin
      excp_vld_p1   <= chk_excp_valid;
      excp_cause_p1 <= chk_excp_valid ? chk_excp_cause : '0;
    end
  end

  assign chk_paddr_valid       = (state_q == ORV64_PMP_ARB_CHECK);
  assign chk_paddr             = slot_paddr_p0;
  assign chk_access_type       = slot_type_p0;
  assign chk_access_byte_width = slot_bw_p0;

  // a flushed response is never presented, even in the flush cycle itself
  assign resp_on         = (state_q == ORV64_PMP_ARB_RESP) && !flush;
  assign resp_valid      = resp_on ? id_to_onehot(slot_owner_p0) : 2'b00;
  assign resp_excp_valid = resp_on && excp_vld_p1;
  assign resp_excp_cause = resp_excp_valid ? excp_cause_p1 : '0;

endmodule

// File: tb/tb_orv64_pmp_req_arb.sv
// Bench for orv64_pmp_req_arb: directed scenarios then random traffic, every
// cycle compared against a transaction-level model of the arbiter.
module tb_orv64_pmp_req_arb;
  import orv64_typedef_pkg::*;

  logic                     clk;
  logic                     rst;
  logic                     flush;
  logic [1:0]               req_valid;
  logic [1:0]               req_ready;
  orv64_paddr_t [1:0]       req_paddr;
  orv64_access_type_t [1:0] req_access_type;
  cpu_byte_mask_t [1:0]     req_byte_width;
  logic [1:0]               resp_valid;
  logic [1:0]               resp_ready;
  logic                     resp_excp_valid;
  orv64_excp_cause_t        resp_excp_cause;
  logic                     chk_paddr_valid;
  orv64_paddr_t             chk_paddr;
  orv64_access_type_t       chk_access_type;
  cpu_byte_mask_t           chk_access_byte_width;
  logic                     chk_excp_valid;
  orv64_excp_cause_t        chk_excp_cause;

  int total = 0;
  int bad   = 0;

  orv64_pmp_req_arb #(.FAIR_RR(1'b1)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .flush                 (flush),
    .req_valid             (req_valid),
    .req_ready             (req_ready),
    .req_paddr             (req_paddr),
    .req_access_type       (req_access_type),
    .req_byte_width        (req_byte_width),
    .resp_valid            (resp_valid),
    .resp_ready            (resp_ready),
    .resp_excp_valid       (resp_excp_valid),
    .resp_excp_cause       (resp_excp_cause),
    .chk_paddr_valid       (chk_paddr_valid),
    .chk_paddr             (chk_paddr),
    .chk_access_type       (chk_access_type),
    .chk_access_byte_width (chk_access_byte_width),
    .chk_excp_valid        (chk_excp_valid),
    .chk_excp_cause        (chk_excp_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in PMP checker: anything above 4 GiB faults; cause is driven even when
  // there is no fault so the arbiter's zeroing of the cause is exercised.
  function automatic logic fault_of(orv64_paddr_t pa);
    return pa[55:32] != 24'd0;
  endfunction

  function automatic orv64_excp_cause_t cause_of(orv64_access_type_t t);
    if (t == ORV64_ACCESS_FETCH) return ORV64_EXCP_INST_ACCESS_FAULT;
    if (t == ORV64_ACCESS_LOAD)  return ORV64_EXCP_LOAD_ACCESS_FAULT;
    return ORV64_EXCP_STORE_ACCESS_FAULT;
  endfunction

  assign chk_excp_valid = chk_paddr_valid && fault_of(chk_paddr);
  assign chk_excp_cause = cause_of(chk_access_type);

  // Reference model: one in-flight transaction with an age counter
  bit                 pend;
  int                 age;
  int                 m_owner;
  int                 m_last;
  orv64_paddr_t       m_paddr;
  orv64_access_type_t m_type;
  cpu_byte_mask_t     m_bw;
  bit                 m_excp;
  orv64_excp_cause_t  m_cause;
  int                 dut_grants[$];

  function automatic int pick(logic [1:0] v, int last);
    case (v)
      2'b01:   return 0;
      2'b10:   return 1;
      2'b11:   return (last == 0) ? 1 : 0;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    pend = 0; age = 0; m_owner = 0; m_last = 0;
    m_paddr = '0; m_type = '0; m_bw = '0; m_excp = 0; m_cause = '0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [1:0]        e_ready;
    logic [1:0]        e_resp;
    logic              e_chkv;
    logic              e_ev;
    orv64_excp_cause_t e_cause;
    int                p;
    e_ready = 2'b00; e_resp = 2'b00; e_chkv = 1'b0; e_ev = 1'b0; e_cause = '0;
    if (!rst) begin
      p = pick(req_valid, m_last);
      if (!pend && !flush && p >= 0) e_ready = 2'(1 << p);
      e_chkv = pend && (age == 0);
      if (pend && age >= 1 && !flush) begin
        e_resp = 2'(1 << m_owner);
        e_ev   = m_excp;
        e_cause = m_excp ? m_cause : 4'd0;
      end
    end
    chk("req_ready", 64'(req_ready), 64'(e_ready));
    chk("resp_valid", 64'(resp_valid), 64'(e_resp));
    chk("resp_excp_valid", 64'(resp_excp_valid), 64'(e_ev));
    chk("resp_excp_cause", 64'(resp_excp_cause), 64'(e_cause));
    chk("chk_paddr_valid", 64'(chk_paddr_valid), 64'(e_chkv));
    chk("chk_paddr", 64'(chk_paddr), 64'(m_paddr));
    chk("chk_access_type", 64'(chk_access_type), 64'(m_type));
    chk("chk_byte_width", 64'(chk_access_byte_width), 64'(m_bw));
    if (!rst && (req_valid & req_ready) != 2'b00) dut_grants.push_back(int'(req_ready[1]));
  endtask

  task automatic model_update();
    int p;
    if (rst) begin
      model_reset();
    end else if (!pend) begin
      p = pick(req_valid, m_last);
      if (!flush && p >= 0) begin
        pend = 1; age = 0; m_owner = p; m_last = p;
        m_paddr = req_paddr[p];
        m_type  = req_access_type[p];
        m_bw    = req_byte_width[p];
        m_excp  = fault_of(req_paddr[p]);
        m_cause = cause_of(req_access_type[p]);
      end
    end else if (flush) begin
      pend = 0;
    end else if (age == 0) begin
      age = 1;
    end else if (resp_ready[m_owner]) begin
      pend = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic rand_req();
    for (int i = 0; i < 2; i++) begin
      req_paddr[i]       = {($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'd0, 32'($urandom)};
      req_access_type[i] = 2'($urandom_range(0, 3));
      req_byte_width[i]  = 8'($urandom);
    end
  endtask

  initial begin
    int n0;
    int n1;
    rst = 1'b1; flush = 1'b0; req_valid = 2'b11; resp_ready = 2'b00;
    rand_req();
    model_reset();
    step();
    step();
    rst = 1'b0;
    req_valid = 2'b00;
    step();

    // Single load on requester 1, no fault
    req_paddr[1] = 56'h0000_8000_1000; req_access_type[1] = ORV64_ACCESS_LOAD;
    req_byte_width[1] = 8'hff; req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    step();
    chk("load_resp_valid", 64'(resp_valid), 64'(2'b10));
    chk("load_excp_valid", 64'(resp_excp_valid), 64'(1'b0));
    resp_ready = 2'b10;
    step();
    resp_ready = 2'b00;

    // Fetch above 4 GiB faults
    req_paddr[0] = 56'h0001_0000_0000; req_access_type[0] = ORV64_ACCESS_FETCH;
    req_byte_width[0] = 8'h0f; req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    step();
    chk("fetch_resp_valid", 64'(resp_valid), 64'(2'b01));
    chk("fetch_excp_valid", 64'(resp_excp_valid), 64'(1'b1));
    chk("fetch_excp_cause", 64'(resp_excp_cause), 64'(ORV64_EXCP_INST_ACCESS_FAULT));
    resp_ready = 2'b01;
    step();

    // Both requesters always valid: 20 requests alternate starting with 1
    dut_grants.delete();
    req_valid = 2'b11; resp_ready = 2'b11;
    for (int i = 0; i < 60; i++) begin
      rand_req();
      step();
    end
    req_valid = 2'b00;
    step(); step();
    chk("rr_count", 64'(dut_grants.size()), 64'd20);
    n0 = 0; n1 = 0;
    foreach (dut_grants[i]) begin
      chk("rr_seq", 64'(dut_grants[i]), 64'((i % 2 == 0) ? 1 : 0));
      if (dut_grants[i] == 0) n0++; else n1++;
    end
    chk("rr_req0_served", 64'(n0), 64'd10);
    chk("rr_req1_served", 64'(n1), 64'd10);

    // Response back-pressure for 5 cycles
    resp_ready = 2'b00; rand_req(); req_valid = 2'b01;
    step();
    req_valid = 2'b11;
    for (int i = 0; i < 6; i++) step();
    req_valid = 2'b00; resp_ready = 2'b01;
    step();
    resp_ready = 2'b00;
    step();

    // Flush in CHECK: no response, pointer unchanged (1 was last)
    req_valid = 2'b10; rand_req();
    step();
    req_valid = 2'b00; flush = 1'b1;
    step();
    flush = 1'b0; req_valid = 2'b11;
    step();
    chk("flush_next_owner", 64'(dut_grants[dut_grants.size() - 1]), 64'd0);
    req_valid = 2'b00; resp_ready = 2'b11;
    step(); step();

    // Asynchronous reset in the middle of RESP
    resp_ready = 2'b00; req_valid = 2'b01; rand_req();
    step();
    req_valid = 2'b00;
    step();
    chk("pre_rst_resp_valid", 64'(resp_valid), 64'(2'b01));
    #2 rst = 1'b1; req_valid = 2'b11;
    #1;
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_chk_valid", 64'(chk_paddr_valid), 64'd0);
    chk("rst_excp_valid", 64'(resp_excp_valid), 64'd0);
    model_reset();
    step();
    rst = 1'b0;
    req_valid = 2'b00;
    step();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rand_req();
      req_valid  = 2'($urandom_range(0, 3));
      resp_ready = 2'($urandom_range(0, 3));
      flush      = ($urandom_range(0, 9) == 0);
      step();
    end
    flush = 1'b0; req_valid = 2'b00; resp_ready = 2'b11;
    step(); step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
